// File: rtl/exu_dispatch_queue.sv
// In-order dispatch FIFO between decode and execute; the head entry is routed to one channel by its group code.
// Optional same-cycle bypass of an empty queue is enabled by defining EXU_DISP_BYPASS_EN.
module exu_dispatch_queue #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int NUM_CH = 6,
  parameter int GRP_W  = 3,
  parameter int INFO_W = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [GRP_W-1:0]             in_grp_i,
  input  logic [INFO_W-1:0]            in_info_i,
  input  logic [XLEN-1:0]              in_op1_i,
  input  logic [XLEN-1:0]              in_op2_i,
  input  logic [XLEN-1:0]              in_pc_i,
  input  logic [4:0]                   in_rd_i,
  input  logic                         flush_i,
  output logic [NUM_CH-1:0]            out_valid_o,
  input  logic [NUM_CH-1:0]            out_ready_i,
  output logic [INFO_W-1:0]            out_info_o,
  output logic [XLEN-1:0]              out_op1_o,
  output logic [XLEN-1:0]              out_op2_o,
  output logic [XLEN-1:0]              out_pc_o,
  output logic [4:0]                   out_rd_o,
  output logic                         illegal_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [GRP_W:0]   NUM_CH_G = (GRP_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [GRP_W-1:0]  grp_mem  [DEPTH];
  logic [INFO_W-1:0] info_mem [DEPTH];
  logic [XLEN-1:0]   op1_mem  [DEPTH];
  logic [XLEN-1:0]   op2_mem  [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [4:0]        rd_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic              active, byp, sel_valid, sel_legal, issue, fire, pop, enq, wr_en, rd_en;
  logic [GRP_W-1:0]  sel_grp;
  logic [INFO_W-1:0] sel_info;
  logic [XLEN-1:0]   sel_op1, sel_op2, sel_pc;
  logic [4:0]        sel_rd;

  assign empty_o    = (count_reg == '0);
  assign full_o     = (count_reg == DEPTH_C);
  assign in_ready_o = !full_o;
  assign count_o    = count_reg;

  // Nothing is presented while the queue is being reset or flushed.
  assign active = rst && !flush_i;

`ifdef EXU_DISP_BYPASS_EN
  assign byp = empty_o && in_valid_i;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    sel_grp  = grp_mem[rd_ptr_reg];
    sel_info = info_mem[rd_ptr_reg];
    sel_op1  = op1_mem[rd_ptr_reg];
    sel_op2  = op2_mem[rd_ptr_reg];
    sel_pc   = pc_mem[rd_ptr_reg];
    sel_rd   = rd_mem[rd_ptr_reg];
    if (byp) begin
      sel_grp  = in_grp_i;
      sel_info = in_info_i;
      sel_op1  = in_op1_i;
      sel_op2  = in_op2_i;
      sel_pc   = in_pc_i;
      sel_rd   = in_rd_i;
    end
  end

  assign sel_valid = active && (!empty_o || byp);
  assign sel_legal = ({1'b0, sel_grp} < NUM_CH_G);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_route
      assign out_valid_o[gi] = sel_valid && sel_legal && (sel_grp == GRP_W'(gi));
    end
  endgenerate

  assign issue     = |out_valid_o;
  assign fire      = |(out_valid_o & out_ready_i);
  assign illegal_o = sel_valid && !sel_legal;
  assign pop       = fire || illegal_o;

  assign out_info_o = issue ? sel_info : '0;
  assign out_op1_o  = issue ? sel_op1  : '0;
  assign out_op2_o  = issue ? sel_op2  : '0;
  assign out_pc_o   = issue ? sel_pc   : '0;
  assign out_rd_o   = issue ? sel_rd   : '0;

  // A bypassed entry that is consumed immediately never touches storage.
  assign enq   = rst && in_valid_i && in_ready_o && !flush_i;
  assign wr_en = enq && !(byp && pop);
  assign rd_en = pop && !byp;

  always_comb begin
    wr_ptr_next = wr_en ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = rd_en ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next  = count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      grp_mem[wr_ptr_reg]  <= in_grp_i;
      info_mem[wr_ptr_reg] <= in_info_i;
      op1_mem[wr_ptr_reg]  <= in_op1_i;
      op2_mem[wr_ptr_reg]  <= in_op2_i;
      pc_mem[wr_ptr_reg]   <= in_pc_i;
      rd_mem[wr_ptr_reg]   <= in_rd_i;
    end
  end

endmodule

// File: tb/tb_exu_dispatch_queue.sv
// Bench for exu_dispatch_queue: directed scenarios plus random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_exu_dispatch_queue;

  typedef struct packed {
    logic [2:0]  grp;
    logic [23:0] info;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [4:0]  rd;
  } ent_t;

  logic        clk, rst, in_valid, in_ready, flush, illegal, empty, full;
  logic [2:0]  in_grp, count;
  logic [23:0] in_info, out_info;
  logic [31:0] in_op1, in_op2, in_pc, out_op1, out_op2, out_pc;
  logic [4:0]  in_rd, out_rd;
  logic [5:0]  out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  ent_t in_ent;
  logic [5:0]  exp_valid;
  logic        exp_ill, m_consume, m_accept, m_byp;
  logic [23:0] exp_info;
  logic [31:0] exp_op1, exp_op2, exp_pc;
  logic [4:0]  exp_rd;

  exu_dispatch_queue dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_grp_i(in_grp), .in_info_i(in_info),
    .in_op1_i(in_op1), .in_op2_i(in_op2), .in_pc_i(in_pc), .in_rd_i(in_rd),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_info_o(out_info), .out_op1_o(out_op1), .out_op2_o(out_op2), .out_pc_o(out_pc),
    .out_rd_o(out_rd), .illegal_o(illegal), .count_o(count), .empty_o(empty), .full_o(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: what the head should be and what the next edge does to the queue.
  task automatic model_eval();
    ent_t h;
    bit   pres;
    in_ent    = '{grp: in_grp, info: in_info, op1: in_op1, op2: in_op2, pc: in_pc, rd: in_rd};
    pres      = 0;
    m_byp     = 0;
    h         = '0;
    if (rst && !flush) begin
      if (q.size() > 0) begin
        h = q[0]; pres = 1;
      end
`ifdef EXU_DISP_BYPASS_EN
      else if (in_valid) begin
        h = in_ent; pres = 1; m_byp = 1;
      end
`endif
    end
    exp_valid = '0; exp_ill = 0; m_consume = 0;
    exp_info = '0; exp_op1 = '0; exp_op2 = '0; exp_pc = '0; exp_rd = '0;
    if (pres) begin
      if (h.grp < 6) begin
        exp_valid = 6'(1) << h.grp;
        exp_info = h.info; exp_op1 = h.op1; exp_op2 = h.op2; exp_pc = h.pc; exp_rd = h.rd;
        m_consume = out_ready[h.grp];
      end else begin
        exp_ill   = 1;
        m_consume = 1;
      end
    end
    m_accept = in_valid && (q.size() < 4) && !flush;
  endtask

  task automatic tick();
    model_eval();
    if (out_valid != 0 || illegal)
      $display("txn head valid=%b illegal=%b ready=%b op1=%h count=%0d", out_valid, illegal, out_ready, out_op1, count);
    @(posedge clk);
    if (!rst || flush) q.delete();
    else begin
      if (m_consume && !m_byp) void'(q.pop_front());
      if (m_accept && !(m_byp && m_consume)) q.push_back(in_ent);
    end
    #1;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic set_idle();
    in_valid = 0; flush = 0; out_ready = '0;
    in_grp = '0; in_info = '0; in_op1 = '0; in_op2 = '0; in_pc = '0; in_rd = '0;
  endtask

  task automatic set_in(input logic [2:0] g, input logic [31:0] op1);
    in_valid = 1; in_grp = g; in_op1 = op1;
    in_op2 = $urandom; in_pc = $urandom; in_info = 24'($urandom); in_rd = 5'($urandom);
  endtask

  task automatic test_reset();
    set_idle();
    rst = 0;
    set_in(3'd2, 32'h1234);
    settle();
    checks++;
    if (out_valid !== 6'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_cycle_quiet got valid=%b illegal=%b want 0", out_valid, illegal);
    end
    tick(); tick();
    rst = 1; set_idle();
    settle();
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_status got count=%0d empty=%b full=%b ready=%b want 0 1 0 1", count, empty, full, in_ready);
    end
    checks++;
    if (out_valid !== 6'b0 || illegal !== 1'b0 || out_op1 !== 0 || out_op2 !== 0 || out_pc !== 0 || out_info !== 0 || out_rd !== 0) begin
      errors++; $display("FAIL reset_outputs got valid=%b illegal=%b op1=%h want all zero", out_valid, illegal, out_op1);
    end
  endtask

  task automatic test_fill();
    set_idle();
    for (int i = 0; i < 5; i++) begin
      set_in(3'd0, 32'(i + 1));
      settle();
      checks++;
      if (in_ready !== (i < 4)) begin
        errors++; $display("FAIL fill_in_ready[%0d] got %b want %b", i, in_ready, (i < 4));
      end
      tick();
    end
    set_idle();
    settle();
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("FAIL fill_status got count=%0d full=%b empty=%b want 4 1 0", count, full, empty);
    end
    checks++;
    if (out_valid !== 6'b000001 || out_op1 !== 32'd1) begin
      errors++; $display("FAIL fill_head got valid=%b op1=%h want 000001 00000001", out_valid, out_op1);
    end
    flush = 1; tick(); flush = 0;
  endtask

  task automatic test_routing();
    logic [5:0]  obs_v[$];
    logic [31:0] obs_d[$];
    logic [2:0]  grps [3] = '{3'd2, 3'd4, 3'd1};
    logic [31:0] data [3] = '{32'h11, 32'h22, 32'h33};
    logic [5:0]  want [3] = '{6'b000100, 6'b010000, 6'b000010};
    set_idle();
    out_ready = '1;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) set_in(grps[k], data[k]); else in_valid = 0;
      settle();
      checks++;
      if (out_valid !== exp_valid || out_op1 !== exp_op1) begin
        errors++; $display("FAIL route_cycle[%0d] got valid=%b op1=%h want %b %h", k, out_valid, out_op1, exp_valid, exp_op1);
      end
      if (out_valid != 0) begin obs_v.push_back(out_valid); obs_d.push_back(out_op1); end
      tick();
    end
    checks++;
    if (obs_v.size() != 3) begin
      errors++; $display("FAIL route_issue_count got %0d want 3", obs_v.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_v[k] !== want[k] || obs_d[k] !== data[k]) begin
          errors++; $display("FAIL route_order[%0d] got %b %h want %b %h", k, obs_v[k], obs_d[k], want[k], data[k]);
        end
      end
    end
    // Channel 4 stalls; the grp 1 entry behind it must wait.
    out_ready = 6'b101111;
    set_in(3'd4, 32'h44); tick();
    set_in(3'd1, 32'h55); tick();
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if (out_valid !== 6'b010000 || out_op1 !== 32'h44) begin
        errors++; $display("FAIL stall_hold[%0d] got valid=%b op1=%h want 010000 00000044", k, out_valid, out_op1);
      end
      tick();
    end
    out_ready = '1;
    tick();
    settle();
    checks++;
    if (out_valid !== 6'b000010 || out_op1 !== 32'h55) begin
      errors++; $display("FAIL stall_release got valid=%b op1=%h want 000010 00000055", out_valid, out_op1);
    end
    tick();
    set_idle(); tick();
  endtask

  task automatic test_wrap();
    set_idle();
    set_in(3'(($urandom_range(0, 5))), 32'h100); tick();
    set_in(3'(($urandom_range(0, 5))), 32'h101); tick();
    out_ready = '1;
    for (int k = 0; k < 10; k++) begin
      set_in(3'($urandom_range(0, 5)), 32'h200 + 32'(k));
      settle();
      checks++;
      if (count !== 3'd2) begin
        errors++; $display("FAIL wrap_count[%0d] got %0d want 2", k, count);
      end
      checks++;
      if (out_valid !== exp_valid || out_op1 !== exp_op1 || out_pc !== exp_pc) begin
        errors++; $display("FAIL wrap_data[%0d] got %b %h want %b %h", k, out_valid, out_op1, exp_valid, exp_op1);
      end
      tick();
    end
    in_valid = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_illegal_flush();
    set_idle();
    set_in(3'd0, 32'hA0); tick();
    set_in(3'd7, 32'hB0); tick();
    set_in(3'd5, 32'hC0); tick();
    in_valid = 0;
    out_ready = 6'b000001;
    settle();
    checks++;
    if (out_valid !== 6'b000001 || illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_pre got valid=%b illegal=%b want 000001 0", out_valid, illegal);
    end
    tick();
    settle();
    checks++;
    if (illegal !== 1'b1 || out_valid !== 6'b0 || out_op1 !== 32'h0 || count !== 3'd2) begin
      errors++; $display("FAIL illegal_head got illegal=%b valid=%b op1=%h count=%0d want 1 0 0 2", illegal, out_valid, out_op1, count);
    end
    tick();
    settle();
    checks++;
    if (illegal !== 1'b0 || count !== 3'd1 || out_valid !== 6'b100000 || out_op1 !== 32'hC0) begin
      errors++; $display("FAIL illegal_after got illegal=%b count=%0d valid=%b op1=%h want 0 1 100000 c0", illegal, count, out_valid, out_op1);
    end
    out_ready = '0;
    set_in(3'd1, 32'hD0); tick();
    set_in(3'd2, 32'hE0); tick();
    set_in(3'd3, 32'hF0);
    flush = 1;
    settle();
    checks++;
    if (count !== 3'd3 || out_valid !== 6'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL flush_cycle got count=%0d valid=%b illegal=%b want 3 0 0", count, out_valid, illegal);
    end
    tick();
    set_idle();
    settle();
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 6'b0) begin
      errors++; $display("FAIL flush_after got count=%0d empty=%b valid=%b want 0 1 0", count, empty, out_valid);
    end
    tick();
    settle();
    checks++;
    if (count !== 3'd0 || out_valid !== 6'b0) begin
      errors++; $display("FAIL flush_dropped got count=%0d valid=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_latency();
    set_idle();
    set_in(3'd3, 32'h77);
    in_op2 = 32'hDEAD;
    out_ready = 6'b001000;
    settle();
`ifdef EXU_DISP_BYPASS_EN
    checks++;
    if (out_valid !== 6'b001000 || out_op2 !== 32'hDEAD) begin
      errors++; $display("FAIL bypass_same_cycle got valid=%b op2=%h want 001000 0000dead", out_valid, out_op2);
    end
    tick();
    set_idle();
    settle();
    checks++;
    if (count !== 3'd0 || out_valid !== 6'b0) begin
      errors++; $display("FAIL bypass_count got count=%0d valid=%b want 0 0", count, out_valid);
    end
`else
    checks++;
    if (out_valid !== 6'b0) begin
      errors++; $display("FAIL latency_same_cycle got valid=%b want 000000", out_valid);
    end
    tick();
    set_idle();
    out_ready = 6'b001000;
    settle();
    checks++;
    if (out_valid !== 6'b001000 || out_op2 !== 32'hDEAD || count !== 3'd1) begin
      errors++; $display("FAIL latency_next_cycle got valid=%b op2=%h count=%0d want 001000 dead 1", out_valid, out_op2, count);
    end
    tick();
    settle();
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL latency_drain got count=%0d want 0", count);
    end
`endif
    set_idle(); tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) >= 2);
      flush = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 60) set_in(3'($urandom_range(0, 7)), $urandom);
      else in_valid = 0;
      out_ready = 6'($urandom);
      settle();
      checks++;
      if (out_valid !== exp_valid || illegal !== exp_ill) begin
        errors++; $display("FAIL rand_route[%0d] got valid=%b illegal=%b want %b %b", k, out_valid, illegal, exp_valid, exp_ill);
      end
      checks++;
      if (out_op1 !== exp_op1 || out_op2 !== exp_op2 || out_pc !== exp_pc || out_info !== exp_info || out_rd !== exp_rd) begin
        errors++; $display("FAIL rand_payload[%0d] got op1=%h pc=%h want %h %h", k, out_op1, out_pc, exp_op1, exp_pc);
      end
      checks++;
      if (count !== 3'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 4) || in_ready !== (q.size() < 4)) begin
        errors++; $display("FAIL rand_status[%0d] got count=%0d empty=%b full=%b ready=%b want count=%0d", k, count, empty, full, in_ready, q.size());
      end
      tick();
    end
    rst = 1;
    set_idle();
    flush = 1; tick(); flush = 0;
  endtask

  initial begin
    rst = 0;
    set_idle();
    test_reset();
    test_fill();
    test_routing();
    test_wrap();
    test_illegal_flush();
    test_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
